// File: rtl/fifo_rd_pkg.sv
// Shared types and helpers for the FIFO read-side controller.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_STREAM     = 2'd1,
        ST_BURST_WAIT = 2'd2,
        ST_BURST      = 2'd3
    } rd_state_e;

    // Width needed to hold a credit count from 0 up to and including depth.
    function automatic int cred_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_obuf.sv
// Small show-ahead output buffer: synchronous push/pop, head always visible.
module rd_obuf #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int OCNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              empty_o,
    output logic [OCNT_W-1:0] count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [OCNT_W-1:0] count_q, count_d;
    logic              full;
    logic              do_push, do_pop;

    assign full    = (count_q == OCNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_push = push_i & (~full | do_pop);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Occupancy next-state from push/pop combination.
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + OCNT_W'(1);
            2'b01:   count_d = count_q - OCNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller: pops a fixed-latency FIFO, buffers words, and feeds a
// valid/ready sink with credit-based back-pressure and an optional burst mode.
//
// state         | meaning
// --------------+-----------------------------------------------------------
// ST_IDLE       | no reads; waits for enable, samples burst_mode
// ST_STREAM     | reads whenever FIFO non-empty and credits available
// ST_BURST_WAIT | waits for FIFO fill level to reach BURST_LEN
// ST_BURST      | issues exactly BURST_LEN reads, then leaves
module fifo_rd_ctrl
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int USEDW_W    = 9,
    parameter int RD_LAT     = 1,
    parameter int OBUF_DEPTH = 4,
    parameter int BURST_LEN  = 16,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               burst_mode,
    input  logic               rd_empty,
    input  logic [USEDW_W-1:0] rd_usedw,
    output logic               rd_req,
    input  logic [DATA_W-1:0]  rd_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [DATA_W-1:0]  m_data,
    output logic               busy,
    output logic [CNT_W-1:0]   rd_count
);

    localparam int                 CRED_W      = cred_width(OBUF_DEPTH);
    localparam logic [USEDW_W-1:0] BURST_LEN_W = USEDW_W'(BURST_LEN);

    rd_state_e          state_q, state_d;
    logic [USEDW_W-1:0] remaining_q, remaining_d;
    logic [CRED_W-1:0]  credits_q, credits_d;
    logic [RD_LAT-1:0]  vld_pipe_q, vld_pipe_d;
    logic [CNT_W-1:0]   rd_count_q;

    logic               burst_start;
    logic               deliver;
    logic               obuf_push;
    logic               obuf_empty;
    logic [DATA_W-1:0]  obuf_head;
    logic [CRED_W-1:0]  obuf_count;

    assign burst_start = (state_q == ST_BURST_WAIT) & enable & (rd_usedw >= BURST_LEN_W);
    assign deliver     = m_valid & m_ready;
    assign obuf_push   = vld_pipe_q[RD_LAT-1];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; a started burst always runs to completion.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (enable) state_d = burst_mode ? ST_BURST_WAIT : ST_STREAM;
            ST_STREAM:     if (!enable) state_d = ST_IDLE;
            ST_BURST_WAIT: begin
                if (!enable)          state_d = ST_IDLE;
                else if (burst_start) state_d = ST_BURST;
            end
            ST_BURST:      if (rd_req && remaining_q == USEDW_W'(1))
                               state_d = enable ? ST_BURST_WAIT : ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end

    // Output logic: FIFO read strobe, gated by emptiness, credits and burst budget.
    always_comb begin
        rd_req = 1'b0;
        if ((state_q == ST_STREAM || (state_q == ST_BURST && remaining_q != '0)) &&
            !rd_empty && credits_q != '0)
            rd_req = 1'b1;
    end

    // Burst budget: loaded on entry to ST_BURST, counted down per issued read.
    always_comb begin
        remaining_d = remaining_q;
        if (burst_start)                      remaining_d = BURST_LEN_W;
        else if (state_q == ST_BURST && rd_req) remaining_d = remaining_q - USEDW_W'(1);
    end

    // Credits: one taken per read issued, one returned per word delivered.
    always_comb begin
        credits_d = credits_q;
        if (rd_req && !deliver)      credits_d = credits_q - CRED_W'(1);
        else if (!rd_req && deliver) credits_d = credits_q + CRED_W'(1);
    end

    // Read-latency tracker: a valid bit per outstanding read, aligned with rd_data on exit.
    always_comb begin
        vld_pipe_d[0] = rd_req;
        for (int i = 1; i < RD_LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
    end

    // Datapath registers: burst budget, credits, latency pipe, delivered counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining_q <= '0;
            credits_q   <= CRED_W'(OBUF_DEPTH);
            vld_pipe_q  <= '0;
            rd_count_q  <= '0;
        end else begin
            remaining_q <= remaining_d;
            credits_q   <= credits_d;
            vld_pipe_q  <= vld_pipe_d;
            if (deliver) rd_count_q <= rd_count_q + CNT_W'(1);
        end
    end

    rd_obuf #(
        .DATA_W (DATA_W),
        .DEPTH  (OBUF_DEPTH)
    ) u_obuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (obuf_push),
        .push_data_i (rd_data),
        .pop_i       (deliver),
        .head_o      (obuf_head),
        .empty_o     (obuf_empty),
        .count_o     (obuf_count)
    );

    // m_data is forced to zero while nothing is buffered so no stale word is ever visible.
    assign m_valid  = ~obuf_empty;
    assign m_data   = m_valid ? obuf_head : '0;
    assign busy     = (state_q != ST_IDLE) | (|vld_pipe_q) | (obuf_count != '0);
    assign rd_count = rd_count_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: FIFO model with fixed read latency, word-level
// reference model of delivery order/timing, plus directed literal checks.
module tb_fifo_rd_ctrl;

    localparam int DATA_W     = 8;
    localparam int USEDW_W    = 9;
    localparam int RD_LAT     = 1;
    localparam int OBUF_DEPTH = 4;
    localparam int BURST_LEN  = 16;
    localparam int CNT_W      = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               enable = 1'b0;
    logic               burst_mode = 1'b0;
    logic               rd_empty;
    logic [USEDW_W-1:0] rd_usedw;
    logic               rd_req;
    logic [DATA_W-1:0]  rd_data;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic [DATA_W-1:0]  m_data;
    logic               busy;
    logic [CNT_W-1:0]   rd_count;

    always #5 clk = ~clk;

    fifo_rd_ctrl #(
        .DATA_W(DATA_W), .USEDW_W(USEDW_W), .RD_LAT(RD_LAT),
        .OBUF_DEPTH(OBUF_DEPTH), .BURST_LEN(BURST_LEN), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .burst_mode(burst_mode),
        .rd_empty(rd_empty), .rd_usedw(rd_usedw), .rd_req(rd_req), .rd_data(rd_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy),
        .rd_count(rd_count)
    );

    int checks = 0;
    int errors = 0;

    // FIFO model (driven by the stimulus process just after each rising edge)
    logic [DATA_W-1:0] fifo_q [$];
    logic [DATA_W-1:0] dpipe [RD_LAT];

    // Reference model (updated by the compare process on falling edges)
    logic [DATA_W-1:0] exp_q [$];
    longint            rdy_q [$];
    longint            cyc = 0;
    int                delivered = 0;
    bit                s_rdreq = 0;
    bit                en_prev = 0;
    bit                model_stream = 0;
    longint            req_log [$];
    logic [DATA_W-1:0] deliv_log [$];
    longint            val_first = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        rd_data  = dpipe[RD_LAT-1];
        rd_empty = (fifo_q.size() == 0);
        rd_usedw = USEDW_W'(fifo_q.size());
    endtask

    task automatic push_word(input logic [DATA_W-1:0] w);
        fifo_q.push_back(w);
        drive_fifo();
    endtask

    // One clock: after the edge, the FIFO pops if the DUT requested in the cycle just ended.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = RD_LAT - 1; i > 0; i--) dpipe[i] = dpipe[i-1];
        if (s_rdreq && fifo_q.size() > 0) dpipe[0] = fifo_q.pop_front();
        else                              dpipe[0] = DATA_W'($urandom);
        drive_fifo();
    endtask

    task automatic clear_logs();
        req_log.delete();
        deliv_log.delete();
        val_first = -1;
    endtask

    // Compare process: every falling edge, check DUT against the word-level model.
    always @(negedge clk) begin : compare
        int outst;
        bit exp_v;
        bit exp_req;
        cyc++;
        if (!rst_n) begin
            chk("rst_rd_req", rd_req, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_data", m_data, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rd_count", rd_count, 0);
            exp_q.delete();
            rdy_q.delete();
            delivered = 0;
            en_prev   = 0;
            s_rdreq   = 0;
        end else begin
            outst = exp_q.size();
            exp_v = (rdy_q.size() > 0) && (rdy_q[0] <= cyc);
            chk("no_req_when_empty", rd_req & rd_empty, 0);
            chk("credit_bound", (outst + int'(rd_req)) <= OBUF_DEPTH, 1);
            chk("m_valid", m_valid, exp_v);
            if (exp_v) chk("m_data", m_data, exp_q[0]);
            chk("rd_count", rd_count, CNT_W'(delivered));
            if (outst > 0) chk("busy_inflight", busy, 1);
            if (model_stream) begin
                // In streaming use the FSM is active exactly when enable was high at the last edge.
                exp_req = en_prev && !rd_empty && (outst < OBUF_DEPTH);
                chk("stream_rd_req", rd_req, exp_req);
            end
            if (m_valid && m_ready && exp_q.size() > 0) begin
                deliv_log.push_back(exp_q[0]);
                exp_q.pop_front();
                rdy_q.pop_front();
                delivered++;
            end
            if (rd_req && fifo_q.size() > 0) begin
                exp_q.push_back(fifo_q[0]);
                rdy_q.push_back(cyc + RD_LAT + 1);
                req_log.push_back(cyc);
            end
            if (val_first < 0 && m_valid) val_first = cyc;
            s_rdreq = rd_req;
            en_prev = enable;
        end
    end

    initial begin : watchdog
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int     k;
        int     n_push;
        longint w16_cyc;
        bit     reached;

        for (int i = 0; i < RD_LAT; i++) dpipe[i] = '0;
        drive_fifo();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Streaming, sink always ready, 10 preloaded words
        model_stream = 1; burst_mode = 0; m_ready = 1;
        for (int i = 0; i < 10; i++) fifo_q.push_back(DATA_W'(i));
        drive_fifo();
        clear_logs();
        enable = 1;
        repeat (25) tick();
        enable = 0;
        repeat (5) tick();
        chk("t1_req_count", req_log.size(), 10);
        if (req_log.size() >= 10) chk("t1_req_consecutive", req_log[9] - req_log[0], 9);
        if (req_log.size() >= 1)  chk("t1_first_valid_lat", val_first - req_log[0], 2);
        chk("t1_deliv_count", deliv_log.size(), 10);
        for (int i = 0; i < deliv_log.size() && i < 10; i++) chk("t1_order", deliv_log[i], i);
        chk("t1_rd_count", rd_count, 10);
        chk("t1_busy_low", busy, 0);

        // Back-pressure: sink stalled for 20 cycles
        clear_logs();
        m_ready = 0;
        for (int i = 0; i < 10; i++) fifo_q.push_back(DATA_W'(i));
        drive_fifo();
        enable = 1;
        repeat (20) tick();
        chk("t2_req_count_stalled", req_log.size(), OBUF_DEPTH);
        chk("t2_m_valid_held", m_valid, 1);
        chk("t2_m_data_held", m_data, 8'h00);
        chk("t2_rd_count_stalled", rd_count, 10);
        m_ready = 1;
        repeat (25) tick();
        enable = 0;
        repeat (5) tick();
        chk("t2_deliv_count", deliv_log.size(), 10);
        for (int i = 0; i < deliv_log.size() && i < 10; i++) chk("t2_order", deliv_log[i], i);
        chk("t2_rd_count", rd_count, 20);
        chk("t2_busy_low", busy, 0);

        // Burst mode with a slow writer (1 word per 8 cycles)
        model_stream = 0; burst_mode = 1; m_ready = 1;
        clear_logs();
        enable = 1;
        k = 0; w16_cyc = -1;
        for (int c = 0; c < 170; c++) begin
            tick();
            if (c % 8 == 0 && c < 140) begin
                push_word(DATA_W'(8'h40 + k));
                k++;
                if (w16_cyc < 0 && fifo_q.size() == BURST_LEN) w16_cyc = cyc + 1;
            end
        end
        chk("t3_req_count", req_log.size(), BURST_LEN);
        if (req_log.size() >= 1)  chk("t3_first_req_after_fill", req_log[0] - w16_cyc, 1);
        if (req_log.size() >= 16) chk("t3_req_consecutive", req_log[15] - req_log[0], 15);
        chk("t3_deliv_count", deliv_log.size(), 16);
        for (int i = 0; i < deliv_log.size() && i < 16; i++) chk("t3_order", deliv_log[i], 8'h40 + i);
        chk("t3_rd_count", rd_count, 36);
        chk("t3_busy_wait", busy, 1);
        chk("t3_fifo_left", fifo_q.size(), 2);

        // Burst with enable dropped during the 5th read
        clear_logs();
        for (int i = 0; i < 16; i++) fifo_q.push_back(DATA_W'(8'h80 + i));
        drive_fifo();
        for (int c = 0; c < 60; c++) begin
            tick();
            if (req_log.size() >= 4) enable = 0;
        end
        chk("t4_req_count", req_log.size(), BURST_LEN);
        if (req_log.size() >= 16) chk("t4_req_consecutive", req_log[15] - req_log[0], 15);
        chk("t4_rd_count", rd_count, 52);
        chk("t4_busy_low", busy, 0);
        chk("t4_fifo_left", fifo_q.size(), 2);
        if (deliv_log.size() >= 16) begin
            chk("t4_first_word", deliv_log[0], 8'h50);
            chk("t4_second_word", deliv_log[1], 8'h51);
            chk("t4_last_word", deliv_log[15], 8'h8D);
        end
        fifo_q.delete();
        drive_fifo();

        // Empty boundary: FIFO toggles between 0 and 1 words, random ready/enable
        burst_mode = 0; model_stream = 1;
        clear_logs();
        n_push = 0;
        for (int c = 0; c < 400; c++) begin
            tick();
            enable  = ($urandom_range(0, 7) != 0);
            m_ready = $urandom_range(0, 1) == 1;
            if (fifo_q.size() == 0 && $urandom_range(0, 1) == 1) begin
                push_word(DATA_W'($urandom));
                n_push++;
            end
        end
        enable = 1; m_ready = 1;
        repeat (20) tick();
        enable = 0;
        repeat (5) tick();
        chk("t5_deliv_count", deliv_log.size(), n_push);
        chk("t5_rd_count", rd_count, CNT_W'(52 + n_push));
        chk("t5_busy_low", busy, 0);

        // Reset with three words in flight/buffered
        m_ready = 0;
        for (int i = 0; i < 3; i++) fifo_q.push_back(DATA_W'(8'hA1 + i));
        drive_fifo();
        enable = 1;
        reached = 0;
        for (int c = 0; c < 20 && !reached; c++) begin
            tick();
            if (exp_q.size() == 3) reached = 1;
        end
        chk("t6_three_outstanding", reached, 1);
        #2;
        rst_n = 0;
        #1;
        chk("t6_async_rd_req", rd_req, 0);
        chk("t6_async_m_valid", m_valid, 0);
        chk("t6_async_m_data", m_data, 0);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_rd_count", rd_count, 0);
        repeat (2) tick();
        rst_n = 1; m_ready = 1;
        clear_logs();
        repeat (15) tick();
        chk("t6_no_stale_valid", val_first, -1);
        chk("t6_no_stale_deliv", deliv_log.size(), 0);
        chk("t6_rd_count_after", rd_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
